// File: rtl/pipelined_ripple_adder_if.sv
// Valid/ready bundle for pipelined_ripple_adder.
//   in_valid/in_ready : operand beat handshake (a, b, cin, sub)
//   out_valid/out_ready : result handshake (s, cout, ovf)
// master = source/sink side that drives operands and out_ready.
// slave  = the adder itself.
interface pipelined_ripple_adder_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor.
// The WIDTH-bit carry chain is cut into SLICE-bit segments, one register stage per segment.
// Each stage adds its slice, forwards its carry, the unconsumed operand bits and the
// already-finished low sum bits, so one beat is accepted per cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : valid/ready bundle (slave modport): a, b, cin, sub in; s, cout, ovf out
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input logic                    clk,
    input logic                    rst,
    pipelined_ripple_adder_if.slave bus
);
    localparam int unsigned STAGES = WIDTH / SLICE;

    // Whole pipe moves together; a full output stage with no taker freezes everything.
    logic adv;

    logic             valid_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             ovf_q   [STAGES];

    logic             v_in    [STAGES];
    logic [WIDTH-1:0] a_in    [STAGES];
    logic [WIDTH-1:0] b_in    [STAGES];
    logic [WIDTH-1:0] sum_in  [STAGES];
    logic             c_in    [STAGES];

    logic [WIDTH-1:0] sum_d   [STAGES];
    logic             carry_d [STAGES];
    logic             ovf_d   [STAGES];

    assign adv = !valid_q[STAGES-1] || bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1; cin only matters in add mode.
            assign v_in[k]   = bus.in_valid;
            assign a_in[k]   = bus.a;
            assign b_in[k]   = bus.sub ? ~bus.b : bus.b;
            assign c_in[k]   = bus.sub | bus.cin;
            assign sum_in[k] = '0;
        end else begin : g_next
            assign v_in[k]   = valid_q[k-1];
            assign a_in[k]   = a_q[k-1];
            assign b_in[k]   = b_q[k-1];
            assign c_in[k]   = carry_q[k-1];
            assign sum_in[k] = sum_q[k-1];
        end

        always_comb begin : ripple
            logic c;
            logic c_msb;
            c        = c_in[k];
            c_msb    = c_in[k];
            sum_d[k] = sum_in[k];
            for (int i = 0; i < int'(SLICE); i++) begin
                // c_msb ends up as the carry into the top bit of this slice.
                c_msb = c;
                sum_d[k][k*SLICE+i] = a_in[k][k*SLICE+i] ^ b_in[k][k*SLICE+i] ^ c;
                c = (a_in[k][k*SLICE+i] & b_in[k][k*SLICE+i]) |
                    (a_in[k][k*SLICE+i] & c) |
                    (b_in[k][k*SLICE+i] & c);
            end
            carry_d[k] = c;
            ovf_d[k]   = c ^ c_msb;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
                ovf_q[k]   <= 1'b0;
            end else if (adv) begin
                valid_q[k] <= v_in[k];
                a_q[k]     <= a_in[k];
                b_q[k]     <= b_in[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
                ovf_q[k]   <= ovf_d[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.s         = sum_q[STAGES-1];
    assign bus.cout      = carry_q[STAGES-1];
    assign bus.ovf       = ovf_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder (WIDTH=16, SLICE=4, four stages).
// Latency convention: the accepting edge is edge 1; out_valid must rise after edge 4.
module tb_pipelined_ripple_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_ripple_adder_if #(.WIDTH(16)) bus ();

    pipelined_ripple_adder #(
        .WIDTH(16),
        .SLICE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vecs = 0;
    int errs = 0;

    // Stream table, expected values worked out by hand.
    logic [15:0] ta  [8];
    logic [15:0] tb  [8];
    logic        tc  [8];
    logic        tsb [8];
    logic [15:0] es  [8];
    logic        ec  [8];
    logic        eo  [8];

    task automatic load_table();
        // 0x1234 + 0x1111
        ta[0] = 16'h1234; tb[0] = 16'h1111; tc[0] = 0; tsb[0] = 0;
        es[0] = 16'h2345; ec[0] = 0; eo[0] = 0;
        // -1 + -1 = -2, carry out, no overflow
        ta[1] = 16'hFFFF; tb[1] = 16'hFFFF; tc[1] = 0; tsb[1] = 0;
        es[1] = 16'hFFFE; ec[1] = 1; eo[1] = 0;
        // min + min wraps to 0
        ta[2] = 16'h8000; tb[2] = 16'h8000; tc[2] = 0; tsb[2] = 0;
        es[2] = 16'h0000; ec[2] = 1; eo[2] = 1;
        // 0x4000 + 0x4000 positive overflow
        ta[3] = 16'h4000; tb[3] = 16'h4000; tc[3] = 0; tsb[3] = 0;
        es[3] = 16'h8000; ec[3] = 0; eo[3] = 1;
        // 0x1000 - 1, no borrow
        ta[4] = 16'h1000; tb[4] = 16'h0001; tc[4] = 0; tsb[4] = 1;
        es[4] = 16'h0FFF; ec[4] = 1; eo[4] = 0;
        // 0 - 1 borrows
        ta[5] = 16'h0000; tb[5] = 16'h0001; tc[5] = 1; tsb[5] = 1;
        es[5] = 16'hFFFF; ec[5] = 0; eo[5] = 0;
        // 0x00F0 + 0x0F0F + 1
        ta[6] = 16'h00F0; tb[6] = 16'h0F0F; tc[6] = 1; tsb[6] = 0;
        es[6] = 16'h1000; ec[6] = 0; eo[6] = 0;
        // 0x7FFF - (-1) overflows, borrow in unsigned terms
        ta[7] = 16'h7FFF; tb[7] = 16'hFFFF; tc[7] = 0; tsb[7] = 1;
        es[7] = 16'h8000; ec[7] = 0; eo[7] = 1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic valid);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = valid;
    endtask

    task automatic drive_idx(input int j);
        drive(ta[j], tb[j], tc[j], tsb[j], 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        #12;
        vecs++; if (bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        vecs++; if (bus.s !== 16'h0) begin
            errs++; $display("FAIL reset_s: got %h want 0000", bus.s);
        end
        vecs++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errs++; $display("FAIL reset_flags: got cout=%b ovf=%b want 0 0", bus.cout, bus.ovf);
        end
        vecs++; if (bus.in_ready !== 1'b1) begin
            errs++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single beat into an idle pipe: checks latency and the result.
    task automatic test_vector(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic cin, input logic sub, input logic [15:0] exp_s,
                               input logic exp_c, input logic exp_o);
        @(negedge clk);
        drive(a, b, cin, sub, 1'b1);
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) bus.in_valid = 1'b0;
            vecs++; if (bus.out_valid !== (n == 4)) begin
                errs++;
                $display("FAIL %s_latency edge%0d: got out_valid=%b want %b",
                         name, n, bus.out_valid, (n == 4));
            end
        end
        vecs++; if (bus.s !== exp_s) begin
            errs++; $display("FAIL %s_s: got %h want %h", name, bus.s, exp_s);
        end
        vecs++; if (bus.cout !== exp_c) begin
            errs++; $display("FAIL %s_cout: got %b want %b", name, bus.cout, exp_c);
        end
        vecs++; if (bus.ovf !== exp_o) begin
            errs++; $display("FAIL %s_ovf: got %b want %b", name, bus.ovf, exp_o);
        end
    endtask

    task automatic test_add();
        test_vector("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    endtask

    task automatic test_carry_chain();
        test_vector("chain_ffff", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        test_vector("ovf_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    endtask

    task automatic test_subtract();
        test_vector("sub_5m7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        test_vector("sub_min", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    endtask

    // Beat j is accepted on edge j+1 and must be presented after edge j+4.
    task automatic test_back_to_back();
        logic exp_v;
        int   j;
        @(negedge clk);
        drive_idx(0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            exp_v = (cyc >= 4 && cyc <= 11);
            vecs++; if (bus.out_valid !== exp_v) begin
                errs++;
                $display("FAIL b2b_valid edge%0d: got %b want %b", cyc, bus.out_valid, exp_v);
            end
            if (exp_v) begin
                j = cyc - 4;
                vecs++; if (bus.s !== es[j] || bus.cout !== ec[j] || bus.ovf !== eo[j]) begin
                    errs++;
                    $display("FAIL b2b_result beat%0d: got s=%h c=%b o=%b want s=%h c=%b o=%b",
                             j, bus.s, bus.cout, bus.ovf, es[j], ec[j], eo[j]);
                end
            end
            @(negedge clk);
            if (cyc < 8) drive_idx(cyc);
            else bus.in_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        drive_idx(0);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e < 3) drive_idx(e);
            else bus.in_valid = 1'b0;
        end
        vecs++; if (bus.out_valid !== 1'b1 || bus.s !== es[0]) begin
            errs++; $display("FAIL bp_first: got v=%b s=%h want v=1 s=%h",
                             bus.out_valid, bus.s, es[0]);
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int e = 5; e <= 7; e++) begin
            @(posedge clk);
            #1;
            vecs++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errs++; $display("FAIL bp_stall edge%0d: got in_ready=%b out_valid=%b want 0 1",
                                 e, bus.in_ready, bus.out_valid);
            end
            vecs++; if (bus.s !== es[0] || bus.cout !== ec[0] || bus.ovf !== eo[0]) begin
                errs++; $display("FAIL bp_hold edge%0d: got s=%h c=%b o=%b want s=%h c=%b o=%b",
                                 e, bus.s, bus.cout, bus.ovf, es[0], ec[0], eo[0]);
            end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            @(posedge clk);
            #1;
            if (j < 3) begin
                vecs++; if (bus.out_valid !== 1'b1 || bus.s !== es[j] || bus.cout !== ec[j] ||
                            bus.ovf !== eo[j]) begin
                    errs++; $display("FAIL bp_drain beat%0d: got v=%b s=%h c=%b o=%b want s=%h",
                                     j, bus.out_valid, bus.s, bus.cout, bus.ovf, es[j]);
                end
            end else begin
                vecs++; if (bus.out_valid !== 1'b0) begin
                    errs++; $display("FAIL bp_no_dup: got out_valid=%b want 0", bus.out_valid);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        drive_idx(4);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e < 4) drive_idx(4 + e);
            else bus.in_valid = 1'b0;
        end
        vecs++; if (bus.out_valid !== 1'b1) begin
            errs++; $display("FAIL rstmid_pre: got out_valid=%b want 1", bus.out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        vecs++; if (bus.out_valid !== 1'b0 || bus.s !== 16'h0) begin
            errs++; $display("FAIL rstmid_async: got out_valid=%b s=%h want 0 0000",
                             bus.out_valid, bus.s);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            vecs++; if (bus.out_valid !== 1'b0) begin
                errs++; $display("FAIL rstmid_stale edge%0d: got out_valid=%b want 0",
                                 e, bus.out_valid);
            end
        end
        test_vector("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    endtask

    initial begin
        load_table();
        test_reset();
        test_add();
        test_carry_chain();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
